alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered result stage directly downstream of the 8-bit ripple adder (f_ADD).
//  Captures sum/carry plus operand MSBs, derives C/Z/N/V flags, buffers under a
//  valid/ready handshake toward the register-file write-back path.
//  Keeps sticky overflow/carry status until explicitly cleared.
// PARAMETERS
//  WIDTH  8  datapath width; must match the adder feeding this stage
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous assert, active-low reset
//  in_valid     in   1      adder result valid this cycle
//  in_ready     out  1      stage can accept in_* this cycle
//  in_sum       in   WIDTH  adder sum output
//  in_car       in   1      adder carry-out
//  in_a_msb     in   1      operand A bit WIDTH-1 (for V)
//  in_b_msb     in   1      operand B bit WIDTH-1 (for V)
//  out_valid    out  1      out_* holds a result
//  out_ready    in   1      consumer accepts out_* this cycle
//  out_sum      out  WIDTH  buffered sum
//  out_flags    out  4      {C,Z,N,V} of buffered result
//  sticky_clr   in   1      clear sticky status (synchronous)
//  sticky_c     out  1      OR of C over all results accepted at output since clear
//  sticky_v     out  1      OR of V over all results accepted at output since clear
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_sum=0, out_flags=0, sticky_c/v=0,
//    buffer empty, in_ready=1 one cycle after release (0 while reset asserted).
//  - Flags computed on input side: C=in_car; Z=(in_sum==0); N=in_sum[WIDTH-1];
//    V=(in_a_msb==in_b_msb)&&(in_sum[WIDTH-1]!=in_a_msb). Stored with sum.
//  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//  - Latency: accepted result appears on out_* the next cycle (1 cycle).
//  - out_* stable while out_valid&&!out_ready; in_* must be held by producer while in_ready=0.
//  - Sticky bits update on output transfer: sticky_c|=C, sticky_v|=V.
//  - sticky_clr and output transfer same cycle: clear wins, then that transfer's
//    C/V are OR'd in (result: sticky = transferred C/V, not lost).
//  - Reset mid-transfer discards all buffered entries; no partial output.
// CONFIGURATION
//  ALU_RES_SKID_EN defined: 2-entry skid buffer, states EMPTY->ONE->TWO.
//    in_ready registered = (state!=TWO). EMPTY+in -> ONE; ONE+in&&!out -> TWO;
//    ONE+in&&out -> ONE (pass-through); ONE+out -> EMPTY; TWO+out -> ONE (skid entry
//    moves to output). Full throughput with stalls, in_ready has no comb path from out_ready.
//  ALU_RES_SKID_EN undefined: single register; in_ready = !out_valid || out_ready
//    (combinational); back-to-back throughput only when out_ready=1.
// STRUCTURE
//  Shared package alu_pkg: WIDTH default, flag bit indices (FLG_C=3,FLG_Z=2,FLG_N=1,
//  FLG_V=0), skid state encoding typedef (EMPTY/ONE/TWO).
//  Sub-module alu_flag_gen: combinational flag derivation (sum,car,msbs -> flags),
//  reusable by other ALU ops. Buffer/FSM and sticky logic stay in this module.
// TESTING
//  1. sum=8'h00,car=1,a_msb=1,b_msb=1, out_ready=1 -> next cycle out_sum=00, flags=C1 Z1 N0 V1.
//  2. sum=8'h80,car=0,a_msb=0,b_msb=0 -> flags=C0 Z0 N1 V1; sticky_v=1 after output transfer.
//  3. out_ready=0, send 3 results (skid build): first two accepted, in_ready=0 on third;
//     release out_ready -> results emerge in order, none dropped or duplicated.
//  4. Random in_valid/out_ready 1000 cycles vs scoreboard -> order and flags exact,
//     out_* never change while stalled.
//  5. sticky_clr same cycle as transfer with C=1 -> sticky_c=1 next cycle; clr alone -> 0.
//  6. Assert rst_n=0 with 2 entries buffered -> out_valid=0 immediately (async), buffer empty.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, {C,Z,N,V} flag bit positions and
// the result-stage skid buffer state encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam int FLG_C = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_N = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {C,Z,N,V} derivation from an adder result; zero latency, no flow control.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] sum_i,
   input  logic             car_i,
   input  logic             a_msb_i,
   input  logic             b_msb_i,
   output logic [3:0]       flags_o
);

   always_comb begin
      flags_o        = '0;
      flags_o[FLG_C] = car_i;
      flags_o[FLG_Z] = (sum_i == '0);
      flags_o[FLG_N] = sum_i[WIDTH-1];
      // Signed overflow: like-signed operands producing a differently-signed sum.
      flags_o[FLG_V] = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered adder result stage with flags and sticky C/V; 1-cycle latency, valid/ready both sides.
// ALU_RES_SKID_EN: 2-entry skid buffer with registered in_ready; otherwise single register with comb in_ready.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_sum_i,
   input  logic             in_car_i,
   input  logic             in_a_msb_i,
   input  logic             in_b_msb_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_sum_o,
   output logic [3:0]       out_flags_o,
   input  logic             sticky_clr_i,
   output logic             sticky_c_o,
   output logic             sticky_v_o
);

   logic [3:0]       in_flags;
   logic             in_xfer, out_xfer;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic [3:0]       out_flags_q, out_flags_d;
   logic             sticky_c_q, sticky_c_d, sticky_v_q, sticky_v_d;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .sum_i   (in_sum_i),
      .car_i   (in_car_i),
      .a_msb_i (in_a_msb_i),
      .b_msb_i (in_b_msb_i),
      .flags_o (in_flags)
   );

   assign in_xfer  = in_valid_i && in_ready_o;
   assign out_xfer = out_valid_o && out_ready_i;

`ifdef ALU_RES_SKID_EN
   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] skid_sum_q, skid_sum_d;
   logic [3:0]       skid_flags_q, skid_flags_d;
   logic             in_ready_q;

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (state_q != EMPTY);

   always_comb begin
      state_d      = state_q;
      out_sum_d    = out_sum_q;
      out_flags_d  = out_flags_q;
      skid_sum_d   = skid_sum_q;
      skid_flags_d = skid_flags_q;
      case (state_q)
         EMPTY: if (in_xfer) begin
            out_sum_d   = in_sum_i;
            out_flags_d = in_flags;
            state_d     = ONE;
         end
         ONE: if (in_xfer && out_xfer) begin
            out_sum_d   = in_sum_i;
            out_flags_d = in_flags;
         end else if (in_xfer) begin
            skid_sum_d   = in_sum_i;
            skid_flags_d = in_flags;
            state_d      = TWO;
         end else if (out_xfer) begin
            state_d = EMPTY;
         end
         TWO: if (out_xfer) begin
            out_sum_d   = skid_sum_q;
            out_flags_d = skid_flags_q;
            state_d     = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         in_ready_q   <= 1'b0;
         skid_sum_q   <= '0;
         skid_flags_q <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= (state_d != TWO);
         skid_sum_q   <= skid_sum_d;
         skid_flags_q <= skid_flags_d;
      end
   end
`else
   logic out_valid_q, out_valid_d;
   logic rdy_en_q;

   // rdy_en_q holds in_ready low during reset and for the edge that releases it.
   assign in_ready_o  = rdy_en_q && (!out_valid_q || out_ready_i);
   assign out_valid_o = out_valid_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_flags_d = out_flags_q;
      if (in_xfer) begin
         out_valid_d = 1'b1;
         out_sum_d   = in_sum_i;
         out_flags_d = in_flags;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         rdy_en_q    <= 1'b1;
      end
   end
`endif

   // A clear in the same cycle as a transfer keeps that transfer's C/V.
   always_comb begin
      sticky_c_d = (sticky_clr_i ? 1'b0 : sticky_c_q) | (out_xfer & out_flags_q[FLG_C]);
      sticky_v_d = (sticky_clr_i ? 1'b0 : sticky_v_q) | (out_xfer & out_flags_q[FLG_V]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sum_q   <= '0;
         out_flags_q <= '0;
         sticky_c_q  <= 1'b0;
         sticky_v_q  <= 1'b0;
      end else begin
         out_sum_q   <= out_sum_d;
         out_flags_q <= out_flags_d;
         sticky_c_q  <= sticky_c_d;
         sticky_v_q  <= sticky_v_d;
      end
   end

   assign out_sum_o   = out_sum_q;
   assign out_flags_o = out_flags_q;
   assign sticky_c_o  = sticky_c_q;
   assign sticky_v_o  = sticky_v_q;

endmodule
